result_browser: RTL and testbench

RESULT_BROWSER -- requirements
Module: result_browser

---
 rtl/result_browser_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/result_browser.sv | 136 +++++++++++++
 tb/tb_result_browser.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_browser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : result_browser_pkg
// Brief   : Shared state encoding and default parameter values for the
//           result browser.
// Rev     : 1.0  initial release
// ============================================================================
package result_browser_pkg;

    localparam int c_def_data_w    = 32;
    localparam int c_def_addr_w    = 16;
    localparam int c_def_hdr_word  = 0;
    localparam int c_def_base_word = 256;
    localparam int c_def_cnt_w     = 8;
    localparam int c_def_db_cycles = 65536;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_ADDR  = 3'd1,
        HDR_LATCH = 3'd2,
        EMPTY     = 3'd3,
        FETCH     = 3'd4,
        SHOW      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-FF synchronizer, stable-time debounce and one-clock pulse on
//           the debounced rising edge.
// Rev     : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int c_cnt_w = $clog2(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_pulse;
    logic [c_cnt_w-1:0] r_cnt;

    // The level flips only after DB_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_sync2;
                r_pulse <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/result_browser.sv
`default_nettype none
// ============================================================================
// Module  : result_browser
// Brief   : After core completion, reads a result count and lets two buttons
//           step through the result entries held in data memory.
// Rev     : 1.0  initial release
// ============================================================================
module result_browser
    import result_browser_pkg::*;
#(
    parameter int DATA_W    = c_def_data_w,
    parameter int ADDR_W    = c_def_addr_w,
    parameter int HDR_WORD  = c_def_hdr_word,
    parameter int BASE_WORD = c_def_base_word,
    parameter int CNT_W     = c_def_cnt_w,
    parameter int DB_CYCLES = c_def_db_cycles
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              finish,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              bus_own,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  index,
    output logic [DATA_W-1:0] value,
    output logic              value_vld
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_bus_own;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_index;
    logic [DATA_W-1:0]  r_value;
    logic               r_value_vld;

    logic               w_up;
    logic               w_down;
    logic               w_press;
    logic [CNT_W-1:0]   w_hdr_cnt;
    logic [CNT_W-1:0]   w_idx_up;
    logic [CNT_W-1:0]   w_idx_dn;
    logic [CNT_W-1:0]   w_idx_sel;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_up),
        .pulse (w_up)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_down),
        .pulse (w_down)
    );

    function automatic logic [ADDR_W-1:0] fetch_addr(input logic [CNT_W-1:0] idx);
        return ADDR_W'(BASE_WORD) + ADDR_W'(idx);
    endfunction

    // Simultaneous presses cancel; count=1 wraps onto itself in both directions.
    assign w_press   = w_up ^ w_down;
    assign w_hdr_cnt = mem_rd[DATA_W-1 -: CNT_W];
    assign w_idx_up  = (r_index == r_count - c_one) ? '0 : r_index + c_one;
    assign w_idx_dn  = (r_index == '0) ? r_count - c_one : r_index - c_one;
    assign w_idx_sel = w_up ? w_idx_up : w_idx_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_bus_own   <= 1'b0;
            r_count     <= '0;
            r_index     <= '0;
            r_value     <= '0;
            r_value_vld <= 1'b0;
        end else if (!finish && r_state != IDLE) begin
            r_state   <= IDLE;
            r_bus_own <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (finish) begin
                        r_state    <= HDR_ADDR;
                        r_bus_own  <= 1'b1;
                        r_mem_addr <= ADDR_W'(HDR_WORD);
                    end
                end
                HDR_ADDR: r_state <= HDR_LATCH;
                HDR_LATCH: begin
                    r_count     <= w_hdr_cnt;
                    r_index     <= '0;
                    r_value_vld <= 1'b0;
                    if (w_hdr_cnt == '0) begin
                        r_state <= EMPTY;
                        r_value <= '0;
                    end else begin
                        r_state    <= FETCH;
                        r_mem_addr <= fetch_addr('0);
                    end
                end
                EMPTY: r_state <= EMPTY;
                FETCH: begin
                    r_state     <= SHOW;
                    r_value     <= mem_rd;
                    r_value_vld <= 1'b1;
                end
                SHOW: begin
                    if (w_press) begin
                        r_state     <= FETCH;
                        r_index     <= w_idx_sel;
                        r_mem_addr  <= fetch_addr(w_idx_sel);
                        r_value_vld <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign bus_own   = r_bus_own;
    assign count     = r_count;
    assign index     = r_index;
    assign value     = r_value;
    assign value_vld = r_value_vld;

endmodule
`default_nettype wire

// File: tb/tb_result_browser.sv
`default_nettype none
// ============================================================================
// Module  : tb_result_browser
// Brief   : Directed self-checking bench for result_browser.
// Rev     : 1.0  initial release
// ============================================================================
module tb_result_browser;

    localparam int c_db = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        finish    = 1'b0;
    logic        btn_up    = 1'b0;
    logic        btn_down  = 1'b0;
    logic [31:0] hdr_word  = 32'h0;
    logic [31:0] mem_rd;
    logic [15:0] mem_addr;
    logic        bus_own;
    logic [7:0]  count;
    logic [7:0]  index;
    logic [31:0] value;
    logic        value_vld;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   vld_drops = 0;
    logic vld_prev  = 1'b0;
    int   d0;
    logic found;

    result_browser #(
        .DATA_W    (32),
        .ADDR_W    (16),
        .HDR_WORD  (0),
        .BASE_WORD (256),
        .CNT_W     (8),
        .DB_CYCLES (c_db)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .finish    (finish),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .bus_own   (bus_own),
        .count     (count),
        .index     (index),
        .value     (value),
        .value_vld (value_vld)
    );

    always #5 clk = ~clk;

    // Memory model: read data follows the address and is sampled on the next edge.
    always_comb begin
        case (mem_addr)
            16'd0:   mem_rd = hdr_word;
            16'd256: mem_rd = 32'hA;
            16'd257: mem_rd = 32'hB;
            16'd258: mem_rd = 32'hC;
            default: mem_rd = 32'h0;
        endcase
    end

    // Each refetch drops value_vld for exactly one cycle.
    always @(negedge clk) begin
        if (vld_prev && !value_vld) vld_drops++;
        vld_prev = value_vld;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        @(negedge clk);
        btn_up   = up;
        btn_down = dn;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(c_db + 8);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  64'(mem_addr),  64'h0);
        chk({tag, "_own"},   64'(bus_own),   64'h0);
        chk({tag, "_count"}, 64'(count),     64'h0);
        chk({tag, "_index"}, 64'(index),     64'h0);
        chk({tag, "_value"}, 64'(value),     64'h0);
        chk({tag, "_vld"},   64'(value_vld), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  exp_idx [4];
        logic [31:0] exp_val [4];
        logic        seq_up  [4];
        seq_up  = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_idx = '{8'd1, 8'd2, 8'd0, 8'd2};
        exp_val = '{32'hB, 32'hC, 32'hA, 32'hC};

        hdr_word = 32'h0300_0000;
        tick(2);
        chk_all_zero("reset");

        @(negedge clk) rst_n = 1'b1;
        tick(3);
        chk("idle_own", 64'(bus_own), 64'h0);

        // Header read then first fetch; valid exactly 4 clocks after finish.
        @(negedge clk) finish = 1'b1;
        tick(1);
        chk("c1_own",  64'(bus_own),   64'h1);
        chk("c1_addr", 64'(mem_addr),  64'h0);
        chk("c1_vld",  64'(value_vld), 64'h0);
        tick(1);
        chk("c2_addr", 64'(mem_addr),  64'h0);
        chk("c2_vld",  64'(value_vld), 64'h0);
        tick(1);
        chk("c3_addr", 64'(mem_addr),  64'd256);
        chk("c3_count", 64'(count),    64'h3);
        chk("c3_vld",  64'(value_vld), 64'h0);
        tick(1);
        chk("c4_vld",   64'(value_vld), 64'h1);
        chk("c4_value", 64'(value),     64'hA);
        chk("c4_index", 64'(index),     64'h0);

        for (int i = 0; i < 4; i++) begin
            press(seq_up[i], ~seq_up[i], c_db + 6);
            chk($sformatf("nav%0d_index", i), 64'(index), 64'(exp_idx[i]));
            chk($sformatf("nav%0d_value", i), 64'(value), 64'(exp_val[i]));
            chk($sformatf("nav%0d_vld", i), 64'(value_vld), 64'h1);
        end

        d0 = vld_drops;
        press(1'b1, 1'b0, c_db - 2);
        chk("glitch_index", 64'(index), 64'h2);
        press(1'b1, 1'b1, c_db + 6);
        chk("both_index", 64'(index),     64'h2);
        chk("both_value", 64'(value),     64'hC);
        chk("no_fetch",   64'(vld_drops), 64'(d0));

        @(negedge clk) finish = 1'b0;
        tick(1);
        chk("drop_own",   64'(bus_own), 64'h0);
        chk("keep_count", 64'(count),   64'h3);
        chk("keep_index", 64'(index),   64'h2);
        chk("keep_value", 64'(value),   64'hC);

        // Empty result set.
        hdr_word = 32'h0000_0000;
        @(negedge clk) finish = 1'b1;
        tick(4);
        chk("empty_count", 64'(count),     64'h0);
        chk("empty_index", 64'(index),     64'h0);
        chk("empty_value", 64'(value),     64'h0);
        chk("empty_vld",   64'(value_vld), 64'h0);
        chk("empty_own",   64'(bus_own),   64'h1);
        press(1'b1, 1'b0, c_db + 6);
        press(1'b0, 1'b1, c_db + 6);
        chk("empty_press_index", 64'(index),     64'h0);
        chk("empty_press_vld",   64'(value_vld), 64'h0);
        chk("empty_press_own",   64'(bus_own),   64'h1);

        // Single entry: press keeps index but refetches.
        @(negedge clk) finish = 1'b0;
        tick(2);
        hdr_word = 32'h0100_0000;
        @(negedge clk) finish = 1'b1;
        tick(4);
        chk("one_count", 64'(count),     64'h1);
        chk("one_value", 64'(value),     64'hA);
        chk("one_vld",   64'(value_vld), 64'h1);
        d0 = vld_drops;
        press(1'b1, 1'b0, c_db + 6);
        chk("one_index",  64'(index),     64'h0);
        chk("one_vld2",   64'(value_vld), 64'h1);
        chk("one_refetch", 64'(vld_drops), 64'(d0 + 1));

        // Abort during FETCH.
        @(negedge clk) btn_up = 1'b1;
        found = 1'b0;
        for (int i = 0; i < c_db + 20; i++) begin
            @(posedge clk);
            #1;
            if (!value_vld) begin
                found = 1'b1;
                break;
            end
        end
        chk("fetch_seen", 64'(found), 64'h1);
        finish = 1'b0;
        tick(1);
        chk("abort_own", 64'(bus_own),   64'h0);
        chk("abort_vld", 64'(value_vld), 64'h0);
        @(negedge clk) btn_up = 1'b0;
        tick(c_db + 8);
        hdr_word = 32'h0300_0000;
        @(negedge clk) finish = 1'b1;
        tick(1);
        chk("reread_addr", 64'(mem_addr), 64'h0);
        chk("reread_own",  64'(bus_own),  64'h1);
        tick(3);
        chk("reread_count", 64'(count),     64'h3);
        chk("reread_value", 64'(value),     64'hA);
        chk("reread_vld",   64'(value_vld), 64'h1);

        // Asynchronous reset while showing, with a press partly debounced.
        @(negedge clk) btn_up = 1'b1;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        btn_up = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick(c_db + 12);
        chk("post_rst_index", 64'(index),     64'h0);
        chk("post_rst_value", 64'(value),     64'hA);
        chk("post_rst_vld",   64'(value_vld), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
